// File: rtl/reaction_duel_controller.sv
// reaction_duel_controller
// Round sequencer and arbiter for the two-player reaction game. It produces a
// pseudo-random pre-GO delay, drives the GO LED, decides who reacted first,
// flags false starts, ties and timeouts, and keeps score up to the match limit.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | after reset, waiting for the first start edge
// S_ARM      | LED off, counting down the random delay; any press is early
// S_GO       | LED on, counting ms; the first press wins the round
// S_RESULT   | round outcome displayed; start edge begins the next round
// S_MATCH    | a player reached the point limit; start edge begins a new match
module reaction_duel_controller #(
  parameter int unsigned TICK_DIV      = 100000,
  parameter int unsigned MIN_DELAY_MS  = 1000,
  parameter int unsigned DELAY_MASK    = 2047,
  parameter int unsigned TIMEOUT_MS    = 9999,
  parameter int unsigned ROUNDS_TO_WIN = 3,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_btn_i,
  input  logic        p1_btn_i,
  input  logic        p2_btn_i,
  output logic        led_o,
  output logic [2:0]  state_o,
  output logic [1:0]  winner_o,
  output logic        false_start_o,
  output logic [13:0] react_time_o,
  output logic [2:0]  score_p1_o,
  output logic [2:0]  score_p2_o,
  output logic        round_done_o,
  output logic        match_over_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [2:0]  WIN_PTS  = 3'(ROUNDS_TO_WIN);
  localparam logic [13:0] TMO      = 14'(TIMEOUT_MS);
  localparam logic [15:0] MIN_DLY  = 16'(MIN_DELAY_MS);
  localparam logic [15:0] DLY_MASK = 16'(DELAY_MASK);
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_GO     = 3'd2,
    S_RESULT = 3'd3,
    S_MATCH  = 3'd4
  } state_t;

  state_t        state_q;
  logic [2:0]    sync1_q, sync2_q, sync3_q, edge_q;
  logic [15:0]   lfsr_q;
  logic [PW-1:0] presc_q;
  logic [15:0]   delay_q;
  logic [13:0]   ms_q;
  logic          led_q;
  logic [1:0]    winner_q;
  logic          false_start_q;
  logic [13:0]   react_time_q;
  logic [2:0]    score_p1_q, score_p2_q;
  logic          round_done_q;
  logic          match_over_q;

  logic          tick;
  logic          start_edge, p1_edge, p2_edge;
  logic [15:0]   delay_load;

  assign tick       = (presc_q == PW'(TICK_DIV - 1));
  assign start_edge = edge_q[0];
  assign p1_edge    = edge_q[1];
  assign p2_edge    = edge_q[2];
  assign delay_load = MIN_DLY + (lfsr_q & DLY_MASK);

  // Two-flop synchroniser plus registered rising-edge pulse for each button.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      edge_q  <= '0;
    end else begin
      sync1_q <= {p2_btn_i, p1_btn_i, start_btn_i};
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      edge_q  <= sync2_q & ~sync3_q;
    end
  end

  // Free-running 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  // Round FSM with ms prescaler, delay/ms counters and all registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      presc_q       <= '0;
      delay_q       <= '0;
      ms_q          <= '0;
      led_q         <= 1'b0;
      winner_q      <= 2'd0;
      false_start_q <= 1'b0;
      react_time_q  <= '0;
      score_p1_q    <= '0;
      score_p2_q    <= '0;
      round_done_q  <= 1'b0;
      match_over_q  <= 1'b0;
    end else begin
      round_done_q <= 1'b0;
      presc_q      <= tick ? '0 : presc_q + PW'(1);
      case (state_q)
        S_IDLE: begin
          if (start_edge) begin
            state_q <= S_ARM;
            delay_q <= delay_load;
            presc_q <= '0;
          end
        end

        S_ARM: begin
          if (p1_edge || p2_edge) begin
            // Early press: the other player takes the point, both early is void.
            state_q       <= S_RESULT;
            round_done_q  <= 1'b1;
            false_start_q <= 1'b1;
            react_time_q  <= '0;
            if (p1_edge && p2_edge) begin
              winner_q <= 2'd3;
            end else if (p1_edge) begin
              winner_q <= 2'd2;
              if (score_p2_q < WIN_PTS) score_p2_q <= score_p2_q + 3'd1;
            end else begin
              winner_q <= 2'd1;
              if (score_p1_q < WIN_PTS) score_p1_q <= score_p1_q + 3'd1;
            end
          end else if (tick) begin
            if (delay_q == 16'd0) begin
              state_q <= S_GO;
              led_q   <= 1'b1;
              ms_q    <= '0;
              presc_q <= '0;
            end else begin
              delay_q <= delay_q - 16'd1;
            end
          end
        end

        S_GO: begin
          if (p1_edge || p2_edge) begin
            state_q       <= S_RESULT;
            led_q         <= 1'b0;
            round_done_q  <= 1'b1;
            false_start_q <= 1'b0;
            react_time_q  <= ms_q;
            if (p1_edge && p2_edge) begin
              winner_q <= 2'd3;
            end else if (p1_edge) begin
              winner_q <= 2'd1;
              if (score_p1_q < WIN_PTS) score_p1_q <= score_p1_q + 3'd1;
            end else begin
              winner_q <= 2'd2;
              if (score_p2_q < WIN_PTS) score_p2_q <= score_p2_q + 3'd1;
            end
          end else if (ms_q >= TMO) begin
            state_q       <= S_RESULT;
            led_q         <= 1'b0;
            round_done_q  <= 1'b1;
            false_start_q <= 1'b0;
            react_time_q  <= TMO;
            winner_q      <= 2'd0;
          end else if (tick) begin
            ms_q <= ms_q + 14'd1;
          end
        end

        S_RESULT: begin
          led_q <= 1'b0;
          if (score_p1_q == WIN_PTS || score_p2_q == WIN_PTS) begin
            state_q      <= S_MATCH;
            match_over_q <= 1'b1;
            winner_q     <= (score_p1_q == WIN_PTS) ? 2'd1 : 2'd2;
          end else if (start_edge) begin
            state_q <= S_ARM;
            delay_q <= delay_load;
            presc_q <= '0;
          end
        end

        S_MATCH: begin
          if (start_edge) begin
            state_q       <= S_ARM;
            match_over_q  <= 1'b0;
            score_p1_q    <= '0;
            score_p2_q    <= '0;
            winner_q      <= 2'd0;
            false_start_q <= 1'b0;
            react_time_q  <= '0;
            delay_q       <= delay_load;
            presc_q       <= '0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          led_q   <= 1'b0;
        end
      endcase
    end
  end

  assign led_o         = led_q;
  assign state_o       = state_q;
  assign winner_o      = winner_q;
  assign false_start_o = false_start_q;
  assign react_time_o  = react_time_q;
  assign score_p1_o    = score_p1_q;
  assign score_p2_o    = score_p2_q;
  assign round_done_o  = round_done_q;
  assign match_over_o  = match_over_q;

endmodule

// File: doc/reaction_duel_controller.md
Name: reaction_duel_controller

Overview:
Round sequencer and arbiter for the two-player version of the reaction game. It generates the pseudo-random pre-GO delay and drives the GO LED. It arbitrates which player's react button arrived first, detects false starts, ties and timeouts, and keeps match score to a best-of-N limit. Its outputs feed the existing 7-segment display path, which shows react_time, the scores and the winner.

Parameters:
TICK_DIV, 100000, clock cycles per 1 ms tick (set to 10 in simulation)
MIN_DELAY_MS, 1000, minimum pre-GO delay in ms
DELAY_MASK, 2047, random delay range mask; must be 2^k-1
TIMEOUT_MS, 9999, GO-phase limit in ms
ROUNDS_TO_WIN, 3, points needed to win the match (1..7)
LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
start_btn  input  1  asynchronous start/next button
p1_btn  input  1  asynchronous player-1 react button
p2_btn  input  1  asynchronous player-2 react button
led  output  1  GO indicator
state  output  3  0 IDLE, 1 ARM, 2 GO, 3 RESULT, 4 MATCH_OVER
winner  output  2  0 none/timeout, 1 P1, 2 P2, 3 tie/void
false_start  output  1  last round ended by an early press
react_time  output  14  winning reaction time in ms
score_p1  output  3  player-1 points
score_p2  output  3  player-2 points
round_done  output  1  1-cycle pulse on entry to RESULT
match_over  output  1  high while in MATCH_OVER

Behaviour:
- Reset:
  - rst is sampled on clk and overrides everything, including mid-round.
  - Reset forces state=IDLE; led, winner, false_start, react_time, scores, round_done and match_over all go to 0.
  - LFSR loads LFSR_SEED; prescaler and counters clear.
- Button input path:
  - Each button passes through a 2-flop synchroniser, then a rising-edge detector.
  - An "edge" is a 1-cycle pulse 3 cycles after the input rises.
  - Held buttons produce exactly one edge.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every cycle when not in reset.
- Tick:
  - The prescaler counts 0..TICK_DIV-1; tick pulses on the wrap.
  - The prescaler clears on every entry to ARM and GO.
- IDLE:
  - start edge -> ARM.
  - delay_cnt loads MIN_DELAY_MS + (lfsr & DELAY_MASK).
- ARM (led=0):
  - delay_cnt decrements on each tick.
  - Both player edges in the same cycle -> RESULT, winner=3, false_start=1, no points.
  - p1 edge alone -> RESULT, winner=2, false_start=1, score_p2+1. p2 edge alone is symmetric.
  - A player edge takes priority over delay expiry in the same cycle.
  - delay_cnt==0 together with a tick -> GO, led=1, ms_cnt=0.
- GO (led=1):
  - ms_cnt increments on each tick.
  - First player edge -> RESULT. That player wins, react_time=ms_cnt in the edge cycle, and the winner's score increments.
  - Both edges in the same cycle -> winner=3, react_time=ms_cnt, no points.
  - ms_cnt reaching TIMEOUT_MS -> RESULT, winner=0, react_time=TIMEOUT_MS.
  - Edges after the first are ignored.
- RESULT:
  - led=0, and round_done pulses in the entry cycle.
  - If either score==ROUNDS_TO_WIN -> MATCH_OVER on the next cycle.
  - Otherwise a start edge -> ARM with a new delay load; winner, false_start and react_time hold until the next RESULT.
- MATCH_OVER:
  - match_over=1, and winner is the match winner (1 or 2).
  - A start edge clears the scores, winner, false_start and react_time, then -> ARM with a new delay.
- Start edges outside IDLE, RESULT and MATCH_OVER are ignored.
- Scores never exceed ROUNDS_TO_WIN. Points awarded this way always end the match before any overflow.
- All outputs are registered.

Test Plan:
- Timing parameters: TICK_DIV=10, MIN_DELAY_MS=20, DELAY_MASK=15, ROUNDS_TO_WIN=2.
- Reset: hold rst 10 cycles, including one mid-GO pulse -> state=0, led=0, scores=0, winner=0 within 1 cycle of rst sampled high.
- Normal round: start 50 cycles; wait led=1; p1_btn high 200 cycles later -> winner=1, react_time=20 (±1 for sync latency), score_p1=1, round_done single pulse, led=0.
- False start: start, p2_btn pressed 5 cycles later while led=0 -> winner=1, false_start=1, score_p1+1, led never rises this round.
- Tie: in GO, drive p1_btn and p2_btn high in the same cycle -> winner=3, no score change; repeat in ARM -> winner=3, false_start=1, no score change.
- Timeout: in GO, no presses for TIMEOUT_MS*TICK_DIV+5 cycles -> winner=0, react_time=TIMEOUT_MS, scores unchanged.
- Match: P2 wins two normal rounds -> MATCH_OVER, match_over=1, winner=2; start -> scores 0, state=ARM. Check across repeated rounds that the delay stays in [MIN_DELAY_MS, MIN_DELAY_MS+15] ms and varies.
